// File: rtl/zone_buf_pkg.sv
// Shared types and default sizing for the zone-brightness buffer controller.
package zone_buf_pkg;

  localparam int unsigned ZONES_DEF     = 360;
  localparam int unsigned AW_DEF        = 9;
  localparam int unsigned DW_DEF        = 16;
  localparam logic [15:0] CLEAR_VAL_DEF = 16'h0000;

  // Sequencer state, also exported on the debug port of the top level.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DRAIN = 2'd3
  } zb_state_e;

endpackage

// File: rtl/zone_buf_skid.sv
// Two-entry output FIFO carrying zone data plus an end-of-frame flag.
// The producer never pushes into a full FIFO; the top level only issues a
// RAM read when a slot is guaranteed to be free when the data returns.
module zone_buf_skid #(
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_data,
  input  logic          i_push_last,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_last,
  output logic [1:0]    o_count,
  output logic          o_pop
);

  logic [DW:0] r_mem [2];
  logic        r_wr;
  logic        r_rd;
  logic [1:0]  r_cnt;
  logic [DW:0] w_head;

  assign w_head  = r_mem[r_rd];
  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = o_valid ? w_head[DW-1:0] : '0;
  assign o_last  = o_valid & w_head[DW];
  assign o_pop   = o_valid & i_ready;
  assign o_count = r_cnt;

  // Storage, pointers and occupancy; the head stays put while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= {i_push_last, i_push_data};
        r_wr        <= ~r_wr;
      end
      if (o_pop) r_rd <= ~r_rd;
      r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, o_pop};
    end
  end

endmodule

// File: rtl/zone_buf_ctrl.sv
// Sequencer/arbiter for the zone-brightness SDP RAM: per-zone writes, bulk
// clear, and a per-frame in-order scan streamed to the LED serializer.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and data/last stay stable while
// valid is high and ready is low.
module zone_buf_ctrl
  import zone_buf_pkg::*;
#(
  parameter int unsigned   ZONES     = ZONES_DEF,
  parameter int unsigned   AW        = AW_DEF,
  parameter int unsigned   DW        = DW_DEF,
  parameter logic [DW-1:0] CLEAR_VAL = DW'(CLEAR_VAL_DEF)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_valid,
  input  logic [AW-1:0] wr_idx,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic          clr,
  input  logic          start,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic          busy,
  output logic          err,
  output logic          ram_cea,
  output logic [AW-1:0] ram_ada,
  output logic [DW-1:0] ram_din,
  output logic          ram_ceb,
  output logic [AW-1:0] ram_adb,
  output logic          ram_oce,
  input  logic [DW-1:0] ram_dout,
  output zb_state_e     dbg_state
);

  localparam logic [AW-1:0] LAST_IDX = AW'(ZONES - 1);

  zb_state_e     r_state;
  logic [AW-1:0] r_ptr;      // clear address in CLEAR, read pointer in SCAN
  logic          r_pend;     // start deferred until the clear finishes
  logic          r_cap;      // read issued last cycle, ram_dout valid now
  logic          r_cap_last;
  logic          r_err;
  logic          r_live;     // holds wr_ready low until the first edge after reset

  logic [1:0]    w_cnt;
  logic          w_pop;
  logic [2:0]    w_occ;
  logic          w_issue;
  logic          w_in_range;
  logic          w_wr_fire;
  logic          w_clearing;
  logic          w_scanning;
  logic          w_drop;

  // Occupancy after this edge's pop plus the read still in flight; issuing
  // only below two keeps the FIFO from overflowing yet sustains 1 beat/cycle.
  assign w_occ      = 3'(w_cnt) + 3'(r_cap) - 3'(w_pop);
  assign w_issue    = (r_state == ST_SCAN) && (w_occ < 3'd2);
  assign w_clearing = (r_state == ST_CLEAR);
  assign w_scanning = (r_state == ST_SCAN) || (r_state == ST_DRAIN);

  // A write to the address being read this cycle is stalled one cycle so the
  // two SDP ports never touch the same word on the same edge.
  assign wr_ready   = r_live && !w_clearing && !(w_issue && (wr_idx == r_ptr));
  assign w_wr_fire  = wr_valid && wr_ready;
  assign w_in_range = ({1'b0, wr_idx} < (AW+1)'(ZONES));

  assign ram_cea = w_clearing || (w_wr_fire && w_in_range);
  assign ram_ada = w_clearing ? r_ptr : (ram_cea ? wr_idx : '0);
  assign ram_din = w_clearing ? CLEAR_VAL : (ram_cea ? wr_data : '0);
  assign ram_ceb = w_issue;
  assign ram_adb = w_issue ? r_ptr : '0;
  assign ram_oce = 1'b1;

  assign w_drop = (start && (w_scanning || (w_clearing && r_pend))) ||
                  (clr && w_scanning);

  assign busy      = (r_state != ST_IDLE) || r_pend;
  assign err       = r_err;
  assign dbg_state = r_state;

  zone_buf_skid #(.DW(DW)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_cap),
    .i_push_data (ram_dout),
    .i_push_last (r_cap_last),
    .i_ready     (out_ready),
    .o_valid     (out_valid),
    .o_data      (out_data),
    .o_last      (out_last),
    .o_count     (w_cnt),
    .o_pop       (w_pop)
  );

  // Sequencer: clear sweep, scan issue, drain, plus read-return tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_pend     <= 1'b0;
      r_cap      <= 1'b0;
      r_cap_last <= 1'b0;
      r_err      <= 1'b0;
      r_live     <= 1'b0;
    end else begin
      r_live     <= 1'b1;
      r_err      <= w_drop || (w_wr_fire && !w_in_range);
      r_cap      <= w_issue;
      r_cap_last <= w_issue && (r_ptr == LAST_IDX);
      case (r_state)
        ST_IDLE: begin
          r_ptr <= '0;
          if (clr) begin
            r_state <= ST_CLEAR;
            r_pend  <= start;
          end else if (start) begin
            r_state <= ST_SCAN;
          end
        end
        ST_CLEAR: begin
          if (start && !r_pend) r_pend <= 1'b1;
          if (r_ptr == LAST_IDX) begin
            r_ptr   <= '0;
            r_pend  <= 1'b0;
            r_state <= (r_pend || start) ? ST_SCAN : ST_IDLE;
          end else begin
            r_ptr <= r_ptr + AW'(1);
          end
        end
        ST_SCAN: begin
          if (w_issue) begin
            if (r_ptr == LAST_IDX) begin
              r_ptr   <= '0;
              r_state <= ST_DRAIN;
            end else begin
              r_ptr <= r_ptr + AW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if ((w_cnt == 2'd0) && !r_cap) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zone_buf_ctrl.sv
// Bench for zone_buf_ctrl: RAM model, zone-content reference array, stream
// scoreboard, and one task per scenario.
module tb_zone_buf_ctrl;
  import zone_buf_pkg::*;

  localparam int          ZONES     = 360;
  localparam int          AW        = 9;
  localparam int          DW        = 16;
  localparam logic [15:0] CLEAR_VAL = 16'h0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid, clr, start, out_ready;
  logic [AW-1:0] wr_idx;
  logic [DW-1:0] wr_data;
  logic          wr_ready, out_valid, out_last, busy, err;
  logic [DW-1:0] out_data;
  logic          ram_cea, ram_ceb, ram_oce;
  logic [AW-1:0] ram_ada, ram_adb;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;
  zb_state_e     dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int err_seen = 0;

  logic [DW:0]   exp_q[$];          // {last, data} per expected beat
  logic [DW-1:0] model_mem [ZONES]; // what each zone should hold
  logic [DW-1:0] ram_mem [512];

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic          prev_last  = 1'b0;

  zone_buf_ctrl #(.ZONES(ZONES), .AW(AW), .DW(DW), .CLEAR_VAL(CLEAR_VAL)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_idx(wr_idx), .wr_data(wr_data), .wr_ready(wr_ready),
    .clr(clr), .start(start),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .err(err),
    .ram_cea(ram_cea), .ram_ada(ram_ada), .ram_din(ram_din),
    .ram_ceb(ram_ceb), .ram_adb(ram_adb), .ram_oce(ram_oce),
    .ram_dout(ram_dout), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // SDP RAM model, one-cycle read latency
  always @(posedge clk) begin
    if (ram_cea) ram_mem[ram_ada] <= ram_din;
    if (ram_ceb) ram_dout <= ram_mem[ram_adb];
  end

  // Scoreboard: stream order/content, stall stability, err count, write range
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (!out_valid || out_data !== prev_data || out_last !== prev_last) begin
          n_errors++;
          $display("FAIL hold_stable: got valid=%0b data=%h last=%0b, required valid=1 data=%h last=%0b",
                   out_valid, out_data, out_last, prev_data, prev_last);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL extra_beat: got data=%h last=%0b, required no beat", out_data, out_last);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) begin
            n_errors++;
            $display("FAIL beat: got data=%h last=%0b, required data=%h last=%0b",
                     out_data, out_last, e[DW-1:0], e[DW]);
          end
        end
      end
      if (ram_cea) begin
        n_checks++;
        if (int'(ram_ada) >= ZONES) begin
          n_errors++;
          $display("FAIL ram_write_range: got ada=%0d, required < %0d", ram_ada, ZONES);
        end
      end
      if (err) err_seen++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_zone(input int idx, input logic [DW-1:0] d);
    bit acc = 0;
    tick();
    wr_valid = 1'b1;
    wr_idx   = AW'(idx);
    wr_data  = d;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (wr_ready) begin acc = 1; break; end
    end
    tick();
    wr_valid = 1'b0;
    n_checks++;
    if (!acc) begin
      n_errors++;
      $display("FAIL write_accept: idx=%0d got no wr_ready in 20 cycles, required accept", idx);
    end else if (idx < ZONES) begin
      model_mem[idx] = d;
    end
  endtask

  task automatic start_frame();
    for (int k = 0; k < ZONES; k++) exp_q.push_back({(k == ZONES-1), model_mem[k]});
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_frame(input int budget);
    bit done = 0;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin done = 1; break; end
    end
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL frame_done: got %0d beats outstanding busy=%0b, required 0 and idle",
               exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; wr_valid = 0; wr_idx = '0; wr_data = '0;
    clr = 0; start = 0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({wr_ready, out_valid, out_last, busy, err, ram_cea, ram_ceb} !== 7'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got wr_ready=%0b valid=%0b last=%0b busy=%0b err=%0b cea=%0b ceb=%0b, required all 0",
               wr_ready, out_valid, out_last, busy, err, ram_cea, ram_ceb);
    end
    n_checks++;
    if (ram_oce !== 1'b1 || out_data !== '0 || ram_ada !== '0 || ram_adb !== '0 || ram_din !== '0) begin
      n_errors++;
      $display("FAIL reset_data: got oce=%0b data=%h ada=%h adb=%h din=%h, required oce=1 rest 0",
               ram_oce, out_data, ram_ada, ram_adb, ram_din);
    end
    tick();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (wr_ready !== 1'b1 || busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_errors++;
      $display("FAIL post_reset: got wr_ready=%0b busy=%0b state=%0d, required 1 0 IDLE",
               wr_ready, busy, dbg_state);
    end
  endtask

  task automatic test_clear();
    int bad = 0;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int c = 0; c < ZONES; c++) begin
      @(negedge clk);
      n_checks++;
      if (ram_cea !== 1'b1 || int'(ram_ada) != c || ram_din !== CLEAR_VAL || wr_ready !== 1'b0 || busy !== 1'b1) begin
        n_errors++;
        if (bad < 5)
          $display("FAIL clear_cycle %0d: got cea=%0b ada=%0d din=%h wr_ready=%0b busy=%0b, required 1 %0d %h 0 1",
                   c, ram_cea, ram_ada, ram_din, wr_ready, busy, c, CLEAR_VAL);
        bad++;
      end
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || ram_cea !== 1'b0) begin
      n_errors++;
      $display("FAIL clear_end: got busy=%0b cea=%0b, required 0 0", busy, ram_cea);
    end
    for (int k = 0; k < ZONES; k++) model_mem[k] = CLEAR_VAL;
    start_frame();
    wait_frame(600);
  endtask

  task automatic test_write_scan();
    int run = 0;
    for (int k = 0; k < ZONES; k++) write_zone(k, DW'(k*3 + 1));
    start_frame();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== (c == 3)) begin
        n_errors++;
        $display("FAIL first_valid cycle %0d: got out_valid=%0b, required %0b", c, out_valid, (c == 3));
      end
    end
    run = out_valid ? 1 : 0;
    for (int t = 0; t < ZONES + 5; t++) begin
      @(negedge clk);
      if (out_valid) run++;
      else break;
    end
    n_checks++;
    if (run != ZONES) begin
      n_errors++;
      $display("FAIL throughput: got %0d consecutive beats, required %0d", run, ZONES);
    end
    wait_frame(100);
  endtask

  task automatic test_backpressure();
    bit done = 0;
    for (int i = 0; i < 40; i++)
      write_zone($urandom_range(0, ZONES-1), DW'($urandom_range(0, 16'hFFFF)));
    start_frame();
    for (int t = 0; t < 4000; t++) begin
      tick();
      out_ready = 1'($urandom_range(0, 1));
      if (exp_q.size() == 0 && !busy) begin done = 1; break; end
    end
    out_ready = 1'b1;
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL backpressure_done: got %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_collision();
    bit found = 0;
    wr_idx  = AW'(200);
    wr_data = 16'hABCD;
    start_frame();
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      if (ram_ceb && int'(ram_adb) == 200) begin found = 1; break; end
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL collision_reach: got no read of zone 200, required one");
    end else begin
      wr_valid = 1'b1;
      #1;
      n_checks++;
      if (wr_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL collision_stall: got wr_ready=%0b, required 0", wr_ready);
      end
      @(negedge clk);
      n_checks++;
      if (wr_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL collision_retry: got wr_ready=%0b, required 1", wr_ready);
      end
      tick();
      wr_valid = 1'b0;
      model_mem[200] = 16'hABCD;
    end
    wait_frame(600);
    start_frame();
    wait_frame(600);
  endtask

  task automatic test_clr_start();
    int n = 0;
    err_seen = 0;
    for (int k = 0; k < ZONES; k++) model_mem[k] = CLEAR_VAL;
    for (int k = 0; k < ZONES; k++) exp_q.push_back({(k == ZONES-1), CLEAR_VAL});
    tick();
    clr = 1'b1; start = 1'b1;
    tick();
    clr = 1'b0; start = 1'b0;
    for (int t = 1; t < 2 * ZONES; t++) begin
      @(negedge clk);
      if (ram_ceb) begin n = t; break; end
    end
    n_checks++;
    if (n != ZONES + 1) begin
      n_errors++;
      $display("FAIL pending_start: got first read in cycle %0d, required %0d", n, ZONES + 1);
    end
    wait_frame(600);
    n_checks++;
    if (err_seen != 0) begin
      n_errors++;
      $display("FAIL clr_start_err: got %0d err pulses, required 0", err_seen);
    end
  endtask

  task automatic test_drop();
    for (int i = 0; i < 20; i++)
      write_zone($urandom_range(0, ZONES-1), DW'($urandom_range(0, 16'hFFFF)));
    start_frame();
    err_seen = 0;
    repeat (50) tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (20) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (20) tick();
    write_zone(400, 16'h1234);
    wait_frame(600);
    repeat (3) tick();
    n_checks++;
    if (err_seen != 3) begin
      n_errors++;
      $display("FAIL drop_err: got %0d err pulses, required 3", err_seen);
    end
    n_checks++;
    if (dbg_state !== ST_IDLE) begin
      n_errors++;
      $display("FAIL drop_state: got state=%0d, required IDLE", dbg_state);
    end
  endtask

  task automatic test_abort();
    start_frame();
    repeat (30) tick();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || ram_ceb !== 1'b0) begin
      n_errors++;
      $display("FAIL abort: got valid=%0b busy=%0b ceb=%0b, required 0 0 0", out_valid, busy, ram_ceb);
    end
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    start_frame();
    wait_frame(600);
  endtask

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Sequence
  initial begin
    test_reset();
    test_clear();
    test_write_scan();
    test_backpressure();
    test_collision();
    test_clr_start();
    test_drop();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
